// File: rtl/bp_table_ctrl_pkg.sv
// Shared types and defaults for the branch-predictor table controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_table_ctrl_pkg;

  // INIT walks the table writing the reset value; RUN serves predict/update.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_INDEX_BITS   = 4;
  localparam int DEF_COUNTER_BITS = 2;
  localparam int DEF_INIT_VALUE   = 1;  // weakly not-taken
  localparam int DEF_STARVE_LIMIT = 2;

endpackage

// File: rtl/bp_table_ctrl_sat.sv
// Saturating up/down step for one predictor counter (sat_counter_next).
// Latency: combinational.
// Backpressure: none; pure function of value_i/taken_i.
// Ports: value_i current count, taken_i resolved direction, next_o new count.
module sat_counter_next
  import bp_table_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_COUNTER_BITS
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             taken_i,
  output logic [WIDTH-1:0] next_o
);

  // Step toward the resolved direction, pinned at 0 and all-ones.
  always_comb begin
    next_o = value_i;
    if (taken_i && (value_i != '1)) begin
      next_o = value_i + 1'b1;
    end else if (!taken_i && (value_i != '0)) begin
      next_o = value_i - 1'b1;
    end
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// Branch-predictor counter table with single shared access slot, predict/update arbitration.
// Latency: prediction returned 1 cycle after req_ready; update visible to the next grant.
// Backpressure: req_ready/upd_ready are the grants; requesters hold until granted, nothing queued.
// Ports: clk/rst (sync, active-high); req_* predict request; pred_* prediction result;
//        upd_* resolved-branch update; init_done high once the table has been initialised.
module bp_table_ctrl
  import bp_table_ctrl_pkg::*;
#(
  parameter int INDEX_BITS   = DEF_INDEX_BITS,
  parameter int COUNTER_BITS = DEF_COUNTER_BITS,
  parameter int INIT_VALUE   = DEF_INIT_VALUE,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [INDEX_BITS-1:0] req_idx,
  output logic                  req_ready,
  output logic                  pred_valid,
  output logic                  pred_taken,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_taken,
  output logic                  upd_ready,
  output logic                  init_done
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int SW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [COUNTER_BITS-1:0] INIT_CNT = COUNTER_BITS'(INIT_VALUE);

  state_e                  state_q;
  logic [INDEX_BITS-1:0]   wptr_q;
  logic [SW-1:0]           starve_q, starve_d;
  logic                    init_done_q;
  logic                    pred_valid_q;
  logic                    pred_taken_q;
  logic [COUNTER_BITS-1:0] table_q [DEPTH];
  logic [COUNTER_BITS-1:0] upd_next;
  logic                    run;
  logic                    starve_full;
  logic                    req_wins;

  // Grants are gated by rst so nothing is handed out in the reset cycle.
  assign run         = (state_q == ST_RUN) && !rst;
  assign starve_full = (starve_q == SW'(STARVE_LIMIT));
  // Update normally owns the slot; a predict that has waited STARVE_LIMIT grants takes it.
  assign req_wins    = req_valid && (!upd_valid || starve_full);
  assign req_ready   = run && req_wins;
  assign upd_ready   = run && upd_valid && !req_wins;

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign init_done  = init_done_q;

  // Count only update grants that a waiting predict lost; any gap in req_valid forgives.
  always_comb begin
    starve_d = starve_q;
    if (!req_valid || req_ready) begin
      starve_d = '0;
    end else if (upd_ready && !starve_full) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      wptr_q       <= '0;
      init_done_q  <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      starve_q     <= '0;
    end else begin
      starve_q     <= starve_d;
      pred_valid_q <= req_ready;
      if (req_ready) begin
        pred_taken_q <= table_q[req_idx][COUNTER_BITS-1];
      end
      case (state_q)
        ST_INIT: begin
          wptr_q <= wptr_q + 1'b1;
          if (&wptr_q) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  sat_counter_next #(
    .WIDTH (COUNTER_BITS)
  ) u_sat (
    .value_i (table_q[upd_idx]),
    .taken_i (upd_taken),
    .next_o  (upd_next)
  );

  // Flop array: the init walk and updates never collide because updates only occur in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        table_q[wptr_q] <= INIT_CNT;
      end else if (upd_ready) begin
        table_q[upd_idx] <= upd_next;
      end
    end
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Self-checking bench for bp_table_ctrl: directed scenarios then randomized traffic.
// Latency: n/a (testbench).
// Backpressure: requesters hold valid/idx until the matching ready is observed.
module tb_bp_table_ctrl;

  localparam int IB    = 4;
  localparam int CB    = 2;
  localparam int INITV = 1;
  localparam int SL    = 2;
  localparam int DEPTH = 1 << IB;
  localparam int CMAX  = (1 << CB) - 1;
  localparam int HALF  = 1 << (CB - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [IB-1:0] req_idx;
  logic          req_ready;
  logic          pred_valid;
  logic          pred_taken;
  logic          upd_valid;
  logic [IB-1:0] upd_idx;
  logic          upd_taken;
  logic          upd_ready;
  logic          init_done;

  bp_table_ctrl #(
    .INDEX_BITS   (IB),
    .COUNTER_BITS (CB),
    .INIT_VALUE   (INITV),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_idx    (req_idx),
    .req_ready  (req_ready),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken),
    .upd_ready  (upd_ready),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: table contents, cycles of init remaining, waiting-grant count.
  int mdl [DEPTH];
  int m_init_left;
  int m_starve;
  bit m_run, m_done, m_pv, m_pt, m_known;

  // Observed values from the most recent step.
  logic o_req_rdy, o_upd_rdy, o_pv, o_pt, o_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample, compare with model, advance model across posedge.
  task automatic step(input bit rv, input int ri, input bit uv, input int ui, input bit ut, input bit r);
    bit e_req, e_upd;
    rst       = r;
    req_valid = rv;
    req_idx   = IB'(ri);
    upd_valid = uv;
    upd_idx   = IB'(ui);
    upd_taken = ut;
    #1;
    o_req_rdy = req_ready;
    o_upd_rdy = upd_ready;
    o_pv      = pred_valid;
    o_pt      = pred_taken;
    o_done    = init_done;
    e_req = !r && m_run && rv && (!uv || m_starve == SL);
    e_upd = !r && m_run && uv && !e_req;
    check("req_ready", o_req_rdy, e_req);
    check("upd_ready", o_upd_rdy, e_upd);
    check("ready_exclusive", o_req_rdy & o_upd_rdy, 0);
    if (m_known) begin
      check("pred_valid", o_pv, m_pv);
      if (m_pv) check("pred_taken", o_pt, m_pt);
      check("init_done", o_done, m_done);
    end
    if (r) begin
      m_known     = 1;
      m_run       = 0;
      m_done      = 0;
      m_init_left = DEPTH;
      m_starve    = 0;
      m_pv        = 0;
      m_pt        = 0;
      for (int i = 0; i < DEPTH; i++) mdl[i] = INITV;
    end else begin
      m_pv = e_req;
      if (e_req) m_pt = (mdl[ri] >= HALF);
      if (e_upd) begin
        if (ut) mdl[ui] = (mdl[ui] < CMAX) ? mdl[ui] + 1 : CMAX;
        else    mdl[ui] = (mdl[ui] > 0) ? mdl[ui] - 1 : 0;
      end
      if (!rv || e_req)             m_starve = 0;
      else if (e_upd && m_starve < SL) m_starve = m_starve + 1;
      if (!m_run) begin
        m_init_left = m_init_left - 1;
        if (m_init_left == 0) begin
          m_run  = 1;
          m_done = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int zeros;
    int n;
    bit pr, pu, put;
    int pri, pui;
    bit got;

    rst = 1; req_valid = 0; req_idx = '0; upd_valid = 0; upd_idx = '0; upd_taken = 0;
    m_known = 0; m_run = 0; m_done = 0; m_starve = 0; m_pv = 0; m_pt = 0; m_init_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mdl[i] = INITV;
    @(negedge clk);

    // Reset for one cycle, then count idle cycles with init_done low.
    step(0, 0, 0, 0, 0, 1);
    check("reset_pred_valid", pred_valid, 0);
    check("reset_pred_taken", pred_taken, 0);
    check("reset_init_done", init_done, 0);
    zeros = 0;
    n = 0;
    do begin
      idle();
      if (o_done === 1'b0) zeros++;
      n++;
    end while (o_done !== 1'b1 && n < 40);
    check("init_zero_cycles", zeros, 16);

    // Predict idx 5 after init: value 1 -> not taken.
    step(1, 5, 0, 0, 0, 0);
    idle();
    check("idx5_pred_valid", o_pv, 1);
    check("idx5_pred_taken", o_pt, 0);

    // Three taken updates to idx 3 saturate at 3, predict taken.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 3, 1, 0);
    step(1, 3, 0, 0, 0, 0);
    idle();
    check("idx3_sat_taken", o_pt, 1);
    // Four not-taken updates floor at 0, predict not taken.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 3, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    idle();
    check("idx3_floor_taken", o_pt, 0);

    // Both requesters continuously valid: upd, upd, req repeating.
    for (int k = 0; k < 9; k++) begin
      step(1, 9, 1, 10, 1, 0);
      check("pattern_req", o_req_rdy, (k % 3) == 2);
    end
    idle();

    // Same-cycle update and predict to idx 7: update first, then predict sees value 2.
    step(1, 7, 1, 7, 1, 0);
    check("idx7_upd_first", o_upd_rdy, 1);
    step(1, 7, 0, 0, 0, 0);
    check("idx7_req_second", o_req_rdy, 1);
    idle();
    check("idx7_pred_taken", o_pt, 1);

    // Reset the cycle after a predict grant: prediction dropped, table re-initialised.
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("rst_inflight_seen", o_pv, 1);
    zeros = 0;
    n = 0;
    do begin
      idle();
      if (n == 0) check("rst_pred_dropped", o_pv, 0);
      if (o_done === 1'b0) zeros++;
      n++;
    end while (o_done !== 1'b1 && n < 40);
    check("reinit_zero_cycles", zeros, 16);
    // One taken update on an entry at 1 gives 2 (taken); anything else would not.
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, i, 1, 0);
      step(1, i, 0, 0, 0, 0);
      idle();
      check("reinit_entry", o_pt, 1);
    end

    // Request held from cycle 5 of INIT: granted exactly in the first RUN cycle.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) idle();
    got = 0;
    n = 0;
    while (!got && n < 40) begin
      step(1, 2, 0, 0, 0, 0);
      check("init_req_hold", o_req_rdy, o_done);
      got = o_req_rdy;
      n++;
    end
    check("init_req_granted", got, 1);
    idle();

    // Randomized traffic with holding requesters and rare resets.
    pr = 0; pu = 0; put = 0; pri = 0; pui = 0;
    for (int c = 0; c < 2000; c++) begin
      bit rr;
      if (!pr && $urandom_range(0, 99) < 50) begin
        pr  = 1;
        pri = $urandom_range(0, DEPTH - 1);
      end
      if (!pu && $urandom_range(0, 99) < 60) begin
        pu  = 1;
        pui = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
        put = $urandom_range(0, 1) == 1;
      end
      rr = ($urandom_range(0, 499) == 0);
      step(pr, pri, pu, pui, put, rr);
      if (o_req_rdy) pr = 0;
      if (o_upd_rdy) pu = 0;
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_table_ctrl.md
BP_TABLE_CTRL -- requirements
Module: bp_table_ctrl

Interface
REQ-001 Parameter INDEX_BITS, default 4, SHALL set the table depth to 2^INDEX_BITS entries.
REQ-002 Parameter COUNTER_BITS, default 2, SHALL set the saturating-counter width per entry.
REQ-003 Parameter INIT_VALUE, default 1, SHALL set the counter value written to every entry during initialisation (weakly not-taken).
REQ-004 Parameter STARVE_LIMIT, default 2, SHALL set the maximum number of consecutive update grants while a predict request waits.
REQ-005 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-007 req_valid  in  1  SHALL indicate a prediction request.
REQ-008 req_idx  in  INDEX_BITS  SHALL give the table index for the prediction request.
REQ-009 req_ready  out  1  SHALL indicate that the prediction request is granted this cycle.
REQ-010 pred_valid  out  1  SHALL indicate that pred_taken is valid.
REQ-011 pred_taken  out  1  SHALL be the predicted direction.
REQ-012 upd_valid  in  1  SHALL indicate a resolved-branch update.
REQ-013 upd_idx  in  INDEX_BITS  SHALL give the table index to update.
REQ-014 upd_taken  in  1  SHALL give the resolved direction.
REQ-015 upd_ready  out  1  SHALL indicate that the update is granted this cycle.
REQ-016 init_done  out  1  SHALL be high once table initialisation is complete.

Function
REQ-017 The FSM SHALL have two states: INIT and RUN.
REQ-018 INIT: the FSM SHALL write INIT_VALUE to entry 0, 1, … 2^INDEX_BITS-1, one entry per cycle, holding req_ready, upd_ready and init_done at 0.
REQ-019 After the last entry is written, the FSM SHALL enter RUN; init_done SHALL rise in the first RUN cycle and stay high until reset.
REQ-020 RUN: the table SHALL perform at most one grant per cycle (one shared access slot).
REQ-021 req_ready and upd_ready SHALL be combinational functions of req_valid, upd_valid, state and the starvation counter, and SHALL never both be high.
REQ-022 Arbitration: update SHALL win over predict unless the starvation counter equals STARVE_LIMIT and req_valid is high, in which case predict SHALL win.
REQ-023 Starvation counter: SHALL increment on an update grant while req_valid is high, and SHALL clear on a predict grant or when req_valid is low; it SHALL saturate at STARVE_LIMIT.
REQ-024 Predict grant in cycle N: pred_valid SHALL be 1 in cycle N+1 with pred_taken equal to the MSB of entry[req_idx] as sampled in cycle N; otherwise pred_valid SHALL be 0.
REQ-025 Update grant: the entry SHALL increment if upd_taken=1 and the entry is below 2^COUNTER_BITS-1; it SHALL decrement if upd_taken=0 and the entry is above 0; otherwise it SHALL hold. The new value SHALL be visible to a grant in the next cycle.
REQ-026 Counter arithmetic SHALL never wrap; the bounds are 0 and 2^COUNTER_BITS-1.
REQ-027 The requester SHALL hold a request until its ready is seen; the block SHALL NOT queue requests.

Reset
REQ-028 When rst=1, the block SHALL enter INIT with the write pointer at 0; pred_valid=0, pred_taken=0, req_ready=0, upd_ready=0, init_done=0, and starvation counter=0.
REQ-029 Reset asserted mid-INIT or mid-RUN SHALL restart initialisation from entry 0; any in-flight prediction SHALL be dropped (pred_valid=0 in the following cycle).

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the default INDEX_BITS/COUNTER_BITS values and INIT_VALUE.
REQ-031 The per-entry saturating increment/decrement SHALL be a sub-module, sat_counter_next: combinational, with inputs value and taken and output next value.
REQ-032 The counter array SHALL be flops (not inferred SRAM), to allow same-cycle reset initialisation semantics.

Verification
REQ-033 Scenario: rst for 1 cycle, then idle -> init_done=0 for exactly 16 cycles, then 1; predict to idx 5 -> pred_taken=0 (value 1).
REQ-034 Scenario: 3 updates taken to idx 3, then predict idx 3 -> counter 1→2→3→3 (saturated); pred_taken=1; a further 4 not-taken updates -> counter 0, pred_taken=0.
REQ-035 Scenario: req_valid and upd_valid held high continuously -> grant pattern upd, upd, req, upd, upd, req…; req_ready and upd_ready never both high.
REQ-036 Scenario: update idx 7 taken and predict idx 7 in the same cycle -> update granted first; the predict granted in the next cycle returns pred_taken=1 (value 2).
REQ-037 Scenario: rst pulsed in RUN on the cycle after a predict grant -> pred_valid=0 the next cycle, init_done=0, re-init takes 16 cycles, and all entries return to 1.
REQ-038 Scenario: request during INIT (req_valid=1, cycle 5) -> req_ready stays 0 until the first RUN cycle, then the request is granted.
